addchk_stim: RTL and testbench



---
 rtl/addchk_pkg.sv | 23 ++
 rtl/addchk_stim_if.sv | 30 +++
 rtl/addchk_lfsr.sv | 32 +++
 rtl/addchk_stim.sv | 164 ++++++++++++++++
 tb/tb_addchk_stim.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addchk_pkg.sv
// Shared types and constants for the adder-check stimulus stage: FSM state
// encoding, LFSR taps and seed handling.
package addchk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED  = 8'h01;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    // An all-zero seed would lock the LFSR, so it is substituted
    function automatic logic [7:0] legal_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? ZERO_SEED_SUB : seed;
    endfunction

endpackage

// File: rtl/addchk_stim_if.sv
// Bundle between the stimulus stage and its surroundings: run control,
// operands toward the adder, the adder result, and the run results.
interface addchk_stim_if #(
    parameter int WIDTH       = 8,
    parameter int NUM_VECTORS = 16
);
    localparam int ERR_W = $clog2(NUM_VECTORS + 1);
    localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [IDX_W-1:0] fail_index;

    modport slave (
        input  start, x,
        output y, z, busy, done, pass, err_count, fail_index
    );

    modport master (
        output start, x,
        input  y, z, busy, done, pass, err_count, fail_index
    );

endinterface

// File: rtl/addchk_lfsr.sv
// 8-bit Fibonacci LFSR that produces the operand sequence; reloads from the
// seed on request and steps only when told to.
module addchk_lfsr
    import addchk_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [7:0] o_state
);

    logic [7:0] r_state;
    logic       w_feedback;

    assign w_feedback = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= legal_seed(SEED);
        end else if (i_load) begin
            r_state <= legal_seed(SEED);
        end else if (i_adv) begin
            r_state <= {r_state[6:0], w_feedback};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/addchk_stim.sv
// Drives pseudo-random operand pairs into an adder, checks its result after a
// settle time and reports pass/fail. Optional ADDCHK_STOP_ON_FAIL_EN ends the
// run at the first mismatch.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for start; results cleared when a run is accepted
//  LOAD      | drive y/z from the LFSR, arm the settle timer
//  SETTLE    | wait SETTLE cycles for the adder output to be stable
//  CHECK     | compare x against y+z, record errors, step to next vector
//  DONE      | results held; start launches a fresh identical run
module addchk_stim
    import addchk_pkg::*;
#(
    parameter int         WIDTH       = 8,
    parameter int         NUM_VECTORS = 16,
    parameter int         SETTLE      = 1,
    parameter logic [7:0] SEED        = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst,
    addchk_stim_if.slave bus
);

    localparam int ERR_W = $clog2(NUM_VECTORS + 1);
    localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [ERR_W-1:0] r_err;
    logic [IDX_W-1:0] r_fail_idx;
    logic [IDX_W-1:0] r_vec_idx;
    logic [CNT_W-1:0] r_settle_cnt;

    logic [7:0]       w_lfsr;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_expected;
    logic             w_mismatch;
    logic             w_last;
    logic             w_lfsr_load;
    logic             w_lfsr_adv;

    addchk_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_lfsr_load),
        .i_adv   (w_lfsr_adv),
        .o_state (w_lfsr)
    );

    assign w_op_a     = WIDTH'(w_lfsr);
    assign w_op_b     = {w_op_a[WIDTH-4:0], w_op_a[WIDTH-1:WIDTH-3]};
    assign w_expected = r_y + r_z;
    // Case inequality so that any X/Z bit on x counts as a mismatch
    assign w_mismatch = (bus.x !== w_expected);
    assign w_last     = (r_vec_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= bus.start;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_load = 1'b0;
        w_lfsr_adv  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_start) begin
                    w_state_nxt = ST_LOAD;
                    w_lfsr_load = 1'b1;
                end
            end
            ST_LOAD: w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
`ifdef ADDCHK_STOP_ON_FAIL_EN
                if (w_last || w_mismatch) begin
`else
                if (w_last) begin
`endif
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_LOAD;
                    w_lfsr_adv  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y          <= '0;
            r_z          <= '0;
            r_err        <= '0;
            r_fail_idx   <= '0;
            r_vec_idx    <= '0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (r_start) begin
                        r_err      <= '0;
                        r_fail_idx <= '0;
                        r_vec_idx  <= '0;
                    end
                end
                ST_LOAD: begin
                    r_y          <= w_op_a;
                    r_z          <= w_op_b;
                    r_settle_cnt <= CNT_LOAD;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != '0) begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err == '0) begin
                            r_fail_idx <= r_vec_idx;
                        end
                        if (r_err != ERR_MAX) begin
                            r_err <= r_err + 1'b1;
                        end
                    end
                    if (!w_last) begin
                        r_vec_idx <= r_vec_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y          = r_y;
    assign bus.z          = r_z;
    assign bus.busy       = (r_state == ST_LOAD) || (r_state == ST_SETTLE) ||
                            (r_state == ST_CHECK);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.pass       = (r_state == ST_DONE) && (r_err == '0);
    assign bus.err_count  = r_err;
    assign bus.fail_index = r_fail_idx;

endmodule

// File: tb/tb_addchk_stim.sv
// Bench for addchk_stim: a behavioural adder with selectable faults drives x,
// and a reference model of the vector sequence predicts every run result.
module tb_addchk_stim;

    localparam int W  = 8;
    localparam int NV = 16;
    localparam int ST = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addchk_stim_if #(.WIDTH(W), .NUM_VECTORS(NV)) bus ();

    addchk_stim #(
        .WIDTH       (W),
        .NUM_VECTORS (NV),
        .SETTLE      (ST),
        .SEED        (8'h01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // 0: correct adder, 1: +1 when y==01, 2: all-X, 3: +1 for y values in bad_y
    int          fault_mode = 0;
    logic [255:0] bad_y = '0;

    always_comb begin
        case (fault_mode)
            1:       bus.x = bus.y + bus.z + ((bus.y == 8'h01) ? 8'd1 : 8'd0);
            2:       bus.x = 'x;
            3:       bus.x = bus.y + bus.z + (bad_y[bus.y] ? 8'd1 : 8'd0);
            default: bus.x = bus.y + bus.z;
        endcase
    end

    // Reference vector sequence: operand A values from the seed-01 LFSR
    logic [7:0] vec_y [NV];

    function automatic logic [7:0] rotl3(input logic [7:0] v);
        return (v << 3) | (v >> 5);
    endfunction

    function automatic bit vec_is_bad(input logic [7:0] v);
        case (fault_mode)
            1:       return (v == 8'h01);
            2:       return 1'b1;
            3:       return bad_y[v];
            default: return 1'b0;
        endcase
    endfunction

    // Predicts error count, first failing index and start-to-done cycle count
    task automatic model_run(output int errs, output int first, output int cyc);
        errs  = 0;
        first = 0;
        cyc   = 1;
        for (int i = 0; i < NV; i++) begin
            cyc += ST + 2;
            if (vec_is_bad(vec_y[i])) begin
                if (errs == 0) first = i;
                errs++;
`ifdef ADDCHK_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
    endtask

    // Starts a run and waits (bounded) for done; cyc is -1 on timeout
    task automatic run_to_done(input bit hold_start, output int cyc,
                               output logic busy1, output logic [7:0] y1,
                               output logic [7:0] z1);
        cyc   = -1;
        busy1 = 1'b0;
        y1    = '0;
        z1    = '0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) busy1 = bus.busy;
            if (c == 2) begin
                y1 = bus.y;
                z1 = bus.z;
            end
            if (bus.done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.y, bus.z} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_yz: got %h/%h want 00/00", bus.y, bus.z);
        end
        n_cmp++;
        if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: busy/done/pass got %b%b%b want 000",
                     bus.busy, bus.done, bus.pass);
        end
        n_cmp++;
        if (bus.err_count !== 5'd0 || bus.fail_index !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_results: err %0d idx %0d want 0 0",
                     bus.err_count, bus.fail_index);
        end
        rst = 1'b0;
    endtask

    // Shared body for a full run against the model; does its own comparisons
    task automatic test_run(input string name, input bit hold_start);
        int exp_err, exp_first, exp_cyc, cyc;
        logic busy1;
        logic [7:0] y1, z1;
        model_run(exp_err, exp_first, exp_cyc);
        run_to_done(hold_start, cyc, busy1, y1, z1);
        n_cmp++;
        if (cyc != exp_cyc) begin
            n_bad++;
            $display("FAIL %s_latency: done after %0d edges want %0d", name, cyc, exp_cyc);
        end
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy_rise: busy got %b want 1", name, busy1);
        end
        n_cmp++;
        if (y1 !== vec_y[0] || z1 !== rotl3(vec_y[0])) begin
            n_bad++;
            $display("FAIL %s_first_vec: y/z got %h/%h want %h/%h",
                     name, y1, z1, vec_y[0], rotl3(vec_y[0]));
        end
        n_cmp++;
        if (bus.err_count !== 5'(exp_err) || bus.fail_index !== 4'(exp_first) ||
            bus.pass !== (exp_err == 0) || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_result: err %0d idx %0d pass %b busy %b want %0d %0d %b 0",
                     name, bus.err_count, bus.fail_index, bus.pass, bus.busy,
                     exp_err, exp_first, (exp_err == 0));
        end
    endtask

    task automatic test_pass_run();
        logic [4:0] err_snap;
        fault_mode = 0;
        test_run("pass_run", 1'b0);
        err_snap = bus.err_count;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.err_count !== err_snap) begin
            n_bad++;
            $display("FAIL done_hold: done %b pass %b err %0d want 1 1 %0d",
                     bus.done, bus.pass, bus.err_count, err_snap);
        end
    endtask

    task automatic test_single_fault();
        fault_mode = 1;
        test_run("fault_v0", 1'b0);
    endtask

    task automatic test_x_input();
        fault_mode = 2;
        test_run("x_input", 1'b0);
    endtask

    task automatic test_fault_v3();
        fault_mode = 3;
        bad_y = '0;
        bad_y[vec_y[3]] = 1'b1;
        test_run("fault_v3", 1'b0);
    endtask

    task automatic test_random_faults();
        for (int r = 0; r < 4; r++) begin
            fault_mode = 3;
            for (int i = 0; i < 256; i++) bad_y[i] = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            test_run($sformatf("rand%0d", r), 1'b0);
        end
    endtask

    task automatic test_mid_run_reset();
        fault_mode = 1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y !== 8'h00 ||
            bus.z !== 8'h00 || bus.err_count !== 5'd0) begin
            n_bad++;
            $display("FAIL mid_reset: busy %b done %b y %h z %h err %0d want 0 0 00 00 0",
                     bus.busy, bus.done, bus.y, bus.z, bus.err_count);
        end
        rst = 1'b0;
        fault_mode = 0;
        test_run("after_reset", 1'b0);
    endtask

    task automatic test_start_held();
        int cyc;
        fault_mode = 0;
        test_run("held_start", 1'b1);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_busy: busy %b done %b want 1 0", bus.busy, bus.done);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.y !== vec_y[0] || bus.z !== rotl3(vec_y[0])) begin
            n_bad++;
            $display("FAIL restart_vec: y/z got %h/%h want %h/%h",
                     bus.y, bus.z, vec_y[0], rotl3(vec_y[0]));
        end
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                cyc = c;
                break;
            end
        end
        n_cmp++;
        if (cyc != NV * (ST + 2) - 1 || bus.pass !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_run: done after %0d edges pass %b want %0d 1",
                     cyc, bus.pass, NV * (ST + 2) - 1);
        end
    endtask

    initial begin
        logic [7:0] s;
        bus.start = 1'b0;
        s = 8'h01;
        for (int i = 0; i < NV; i++) begin
            vec_y[i] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end

        test_reset();
        test_pass_run();
        test_single_fault();
        test_x_input();
        test_fault_v3();
        test_random_faults();
        test_mid_run_reset();
        test_start_held();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
